// File: rtl/jump_target_encoder.sv
// Encodes an absolute byte target into a MIPS branch offset (16-bit) or jump index (26-bit).
// Four-state multi-cycle FSM; every output is a register and is independent of the current inputs.
module jump_target_encoder (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        Mode,
    input  logic [31:0] PC,
    input  logic [31:0] Target,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [25:0] Field,
    output logic        ErrAlign,
    output logic        ErrRange
);

    typedef enum logic [1:0] {IDLE, CALC, CHECK, RESP} state_t;

    state_t      state_q, state_d;
    logic        mode_q;
    logic [31:0] pc_q, tgt_q, pca4_q;
    logic [25:0] field_q, field_d;
    logic        ea_q, ea_d, er_q, er_d;
    logic        rr_q, rv_q;
    logic [31:0] diff;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ReqValid) state_d = CALC;
            CALC:    state_d = CHECK;
            CHECK:   state_d = RESP;
            RESP:    if (RespReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The result is always produced; error flags are advisory and independent of each other.
    always_comb begin
        diff    = tgt_q - pca4_q;
        field_d = '0;
        ea_d    = 1'b0;
        er_d    = 1'b0;
        if (mode_q) begin
            ea_d    = |tgt_q[1:0];
            er_d    = (tgt_q[31:28] != pca4_q[31:28]);
            field_d = tgt_q[27:2];
        end else begin
            ea_d    = |diff[1:0];
            er_d    = !((&diff[31:17]) || !(|diff[31:17]));
            field_d = {10'b0, diff[17:2]};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            pc_q    <= '0;
            tgt_q   <= '0;
            pca4_q  <= '0;
            field_q <= '0;
            ea_q    <= 1'b0;
            er_q    <= 1'b0;
            rr_q    <= 1'b1;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= (state_d == IDLE);
            rv_q    <= (state_d == RESP);
            case (state_q)
                IDLE: if (ReqValid) begin
                    mode_q <= Mode;
                    pc_q   <= PC;
                    tgt_q  <= Target;
                end
                CALC:  pca4_q <= pc_q + 32'd4;
                CHECK: begin
                    field_q <= field_d;
                    ea_q    <= ea_d;
                    er_q    <= er_d;
                end
                default: ;
            endcase
        end
    end

    assign ReqReady  = rr_q;
    assign RespValid = rv_q;
    assign Field     = field_q;
    assign ErrAlign  = ea_q;
    assign ErrRange  = er_q;

endmodule

// File: tb/tb_jump_target_encoder.sv
// Self-checking bench for jump_target_encoder: directed limits, backpressure, reset, throughput, random round-trip.
module tb_jump_target_encoder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        Mode = 1'b0;
    logic [31:0] PC = '0;
    logic [31:0] Target = '0;
    logic        RespValid;
    logic        RespReady = 1'b0;
    logic [25:0] Field;
    logic        ErrAlign;
    logic        ErrRange;

    int total = 0;
    int bad = 0;

    jump_target_encoder dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .Mode(Mode), .PC(PC), .Target(Target), .RespValid(RespValid),
        .RespReady(RespReady), .Field(Field), .ErrAlign(ErrAlign), .ErrRange(ErrRange)
    );

    always #5 Clk = ~Clk;

    // Reference model: plain integer arithmetic on the encoding rules.
    function automatic void model(input logic m, input logic [31:0] pc, input logic [31:0] tgt,
                                  output logic [25:0] f, output logic ea, output logic er);
        longint two32 = 64'h1_0000_0000;
        longint p4    = (longint'(pc) + 4) % two32;
        longint t     = longint'(tgt);
        longint d;
        if (m) begin
            ea = (t % 4) != 0;
            er = (t / 64'h1000_0000) != (p4 / 64'h1000_0000);
            f  = 26'((t % 64'h1000_0000) / 4);
        end else begin
            d = t - p4;
            if (d >= 64'h8000_0000) d = d - two32;
            if (d < -64'sh8000_0000) d = d + two32;
            ea = (d % 4) != 0;
            er = (d < -131072) || (d > 131071);
            f  = 26'(((d + 64'h4_0000_0000) / 4) % 65536);
        end
    endfunction

    // Issues one request; reports observed response, latency and handshake behaviour.
    task automatic drive(input logic m, input logic [31:0] pc, input logic [31:0] tgt, input int stall,
                         output logic [25:0] f, output logic ea, output logic er, output int lat,
                         output logic stable_ok, output logic busy_ok, output logic post_rdy,
                         output logic post_rv);
        int w = 0;
        stable_ok = 1'b1;
        busy_ok   = 1'b1;
        while (!ReqReady && w < 20) begin @(negedge Clk); w++; end
        ReqValid = 1'b1; Mode = m; PC = pc; Target = tgt;
        @(negedge Clk);
        ReqValid = 1'b0; Mode = ~m; PC = $urandom; Target = $urandom;
        lat = 1;
        if (ReqReady) busy_ok = 1'b0;
        while (!RespValid && lat < 10) begin
            @(negedge Clk); lat++;
            if (ReqReady) busy_ok = 1'b0;
        end
        f = Field; ea = ErrAlign; er = ErrRange;
        for (int i = 0; i < stall; i++) begin
            @(negedge Clk);
            if (Field !== f || ErrAlign !== ea || ErrRange !== er || RespValid !== 1'b1) stable_ok = 1'b0;
            if (ReqReady) busy_ok = 1'b0;
        end
        RespReady = 1'b1;
        @(negedge Clk);
        RespReady = 1'b0;
        post_rdy = ReqReady;
        post_rv  = RespValid;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        total++;
        if (ReqReady !== 1'b1 || RespValid !== 1'b0 || Field !== 26'd0 || ErrAlign !== 1'b0 || ErrRange !== 1'b0) begin
            bad++;
            $display("FAIL reset: rr=%b rv=%b field=%h ea=%b er=%b want 1 0 0 0 0",
                     ReqReady, RespValid, Field, ErrAlign, ErrRange);
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_directed();
        logic        tm [10];
        logic [31:0] tp [10];
        logic [31:0] tt [10];
        logic [25:0] tf [10];
        logic [1:0]  te [10];
        logic [25:0] f;
        logic ea, er, so, bo, pr, pv;
        int lat;
        tm = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        tp = '{32'h00400000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00400000, 32'hFFFFFFFC,
               32'hFFFFFFFC, 32'h0040001C, 32'h0040001C, 32'hFFFFFFFC, 32'h00000000};
        tt = '{32'h00400010, 32'h00020000, 32'h0001FFFC, 32'h00400012, 32'hFFFE0000,
               32'hFFFDFFFC, 32'h0FFFFFF0, 32'h10000000, 32'h00000100, 32'h00100001};
        tf = '{26'h0000003, 26'h0008000, 26'h0007FFF, 26'h0000003, 26'h0008000,
               26'h0007FFF, 26'h3FFFFFC, 26'h0000000, 26'h0000040, 26'h000FFFF};
        te = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b11};
        for (int i = 0; i < 10; i++) begin
            drive(tm[i], tp[i], tt[i], 0, f, ea, er, lat, so, bo, pr, pv);
            total++;
            if (f !== tf[i] || {ea, er} !== te[i]) begin
                bad++;
                $display("FAIL directed[%0d]: field=%h ea=%b er=%b want field=%h ea=%b er=%b",
                         i, f, ea, er, tf[i], te[i][1], te[i][0]);
            end
            total++;
            if (lat !== 3 || !bo || pr !== 1'b1 || pv !== 1'b0) begin
                bad++;
                $display("FAIL directed_timing[%0d]: lat=%0d busy_ok=%b post_rdy=%b post_rv=%b want 3 1 1 0",
                         i, lat, bo, pr, pv);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [25:0] f;
        logic ea, er, so, bo, pr, pv;
        int lat;
        drive(1'b0, 32'h00400020, 32'h00400000, 5, f, ea, er, lat, so, bo, pr, pv);
        total++;
        if (f !== 26'h000FFF7 || ea !== 1'b0 || er !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_value: field=%h ea=%b er=%b want 000fff7 0 0", f, ea, er);
        end
        total++;
        if (!so || !bo || pr !== 1'b1 || pv !== 1'b0 || lat !== 3) begin
            bad++;
            $display("FAIL backpressure_hold: stable=%b busy_ok=%b post_rdy=%b post_rv=%b lat=%0d want 1 1 1 0 3",
                     so, bo, pr, pv, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [25:0] f;
        logic ea, er, so, bo, pr, pv;
        int lat;
        int seen = 0;
        ReqValid = 1'b1; Mode = 1'b0; PC = 32'h00001000; Target = 32'h00001100;
        @(negedge Clk);
        ReqValid = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        total++;
        if (ReqReady !== 1'b1 || RespValid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: rr=%b rv=%b want 1 0", ReqReady, RespValid);
        end
        RespReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (RespValid) seen++;
        end
        RespReady = 1'b0;
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_mid_discard: resp_cycles=%0d want 0", seen);
        end
        drive(1'b1, 32'h0040001C, 32'h00400100, 0, f, ea, er, lat, so, bo, pr, pv);
        total++;
        if (f !== 26'h0100040 || ea !== 1'b0 || er !== 1'b0 || lat !== 3) begin
            bad++;
            $display("FAIL reset_mid_after: field=%h ea=%b er=%b lat=%0d want 0100040 0 0 3", f, ea, er, lat);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        RespReady = 1'b1;
        ReqValid  = 1'b1; Mode = 1'b1; PC = 32'h00400000; Target = 32'h00400040;
        for (int i = 0; i < 40; i++) begin
            if (ReqReady) acc++;
            @(negedge Clk);
        end
        ReqValid = 1'b0;
        repeat (5) @(negedge Clk);
        RespReady = 1'b0;
        total++;
        if (acc != 10) begin
            bad++;
            $display("FAIL back_to_back: accepts=%0d in 40 cycles want 10", acc);
        end
    endtask

    task automatic test_random();
        logic [25:0] f, ef;
        logic ea, er, eea, eer, so, bo, pr, pv, m;
        logic [31:0] pc, tgt, dec;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            m  = $urandom_range(0, 1);
            pc = $urandom;
            if ($urandom_range(0, 3) == 0) pc = 32'hFFFFFFFC;
            case ($urandom_range(0, 2))
                0: tgt = pc + 32'd4 + 32'($signed($urandom_range(0, 32'h7FFFF)) - 32'sh40000);
                1: tgt = {pc[31:28], 28'($urandom)};
                default: tgt = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) tgt[1:0] = 2'b00;
            drive(m, pc, tgt, $urandom_range(0, 2), f, ea, er, lat, so, bo, pr, pv);
            model(m, pc, tgt, ef, eea, eer);
            total++;
            if (f !== ef || ea !== eea || er !== eer) begin
                bad++;
                $display("FAIL random[%0d] m=%b pc=%h tgt=%h: field=%h ea=%b er=%b want %h %b %b",
                         n, m, pc, tgt, f, ea, er, ef, eea, eer);
            end
            total++;
            if (lat !== 3 || !so || !bo || pr !== 1'b1 || pv !== 1'b0) begin
                bad++;
                $display("FAIL random_timing[%0d]: lat=%0d stable=%b busy_ok=%b post_rdy=%b post_rv=%b",
                         n, lat, so, bo, pr, pv);
            end
            if (!ea && !er) begin
                if (m) dec = {pc[31:28] + 4'(pc[27:0] >= 28'hFFFFFFC), f, 2'b00};
                else   dec = pc + 32'd4 + {{14{f[15]}}, f[15:0], 2'b00};
                if (m && pc == 32'hFFFFFFFC) dec = {4'h0, f, 2'b00};
                total++;
                if (dec !== tgt) begin
                    bad++;
                    $display("FAIL roundtrip[%0d] m=%b pc=%h: decoded=%h want %h", n, m, pc, dec, tgt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
